// File: rtl/mul_ctrl.sv
// mul_ctrl -- sequencer that turns RISC-V M-extension multiply requests
// (MUL, MULH, MULHSU, MULHU) into a single unsigned multiply, then applies the
// sign correction and picks the requested result half.
//
// A one-entry result cache holds the last full 64-bit signed-corrected
// product. A MUL request can reuse any cached product of the same operands,
// because the low 32 bits do not depend on signedness.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   ext_start  CPU request, sampled only in IDLE
//   ext_func3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx unsupported
//   ext_a/b    CPU operands (rs1, rs2)
//   ext_r      result word, held until the next completion
//   ext_done   one-cycle completion pulse
//   ext_err    high together with ext_done for aborted or unsupported ops
//   busy       high in every state except IDLE
//   mul_start  one-cycle launch pulse to the unsigned multiplier
//   mul_a/b    unsigned operand magnitudes, driven from LAUNCH through WAIT
//   mul_p      unsigned 64-bit product, valid while mul_done=1
//   mul_done   multiplier completion (pulse or level)
module mul_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_start,
  input  logic [2:0]  ext_func3,
  input  logic [31:0] ext_a,
  input  logic [31:0] ext_b,
  output logic [31:0] ext_r,
  output logic        ext_done,
  output logic        ext_err,
  output logic        busy,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  input  logic        mul_done
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Registered request
  logic [31:0] op_a_reg, op_b_reg;
  logic [2:0]  op_f_reg;

  // Wait counter, captured product, result and error flag
  logic [CW-1:0] cnt_reg;
  logic [63:0]   prod_reg;
  logic [31:0]   r_reg;
  logic          err_reg;

  // One-entry result cache
  logic        cache_valid_reg;
  logic [31:0] cache_a_reg, cache_b_reg;
  logic [1:0]  cache_mode_reg;
  logic [63:0] cache_p_reg;

  // Operand signedness and magnitudes of the registered request
  logic        a_neg, b_neg, neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] fix_p;
  logic        cache_hit;

  function automatic logic [31:0] pick(input logic [2:0] f, input logic [63:0] p);
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  always_comb begin
    // a is signed for MULH and MULHSU, b only for MULH
    a_neg = ((op_f_reg == 3'b001) || (op_f_reg == 3'b010)) && op_a_reg[31];
    b_neg = (op_f_reg == 3'b001) && op_b_reg[31];
    neg   = a_neg ^ b_neg;
    mag_a = a_neg ? (~op_a_reg + 32'd1) : op_a_reg;
    mag_b = b_neg ? (~op_b_reg + 32'd1) : op_b_reg;
    fix_p = neg ? (~prod_reg + 64'd1) : prod_reg;
  end

  // Compared against the live request because it is evaluated in the same
  // IDLE cycle in which the request is being registered.
  assign cache_hit = cache_valid_reg
                  && (ext_a == cache_a_reg)
                  && (ext_b == cache_b_reg)
                  && ((cache_mode_reg == ext_func3[1:0]) || (ext_func3 == 3'b000));

  assign ext_r = r_reg;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    mul_start  = 1'b0;
    ext_done   = 1'b0;
    ext_err    = 1'b0;
    mul_a      = 32'd0;
    mul_b      = 32'd0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (ext_start) begin
          if (ext_func3[2] || cache_hit) begin
            state_next = DONE;
          end else begin
            state_next = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        mul_start  = 1'b1;
        mul_a      = mag_a;
        mul_b      = mag_b;
        state_next = WAIT;
      end
      WAIT: begin
        mul_a = mag_a;
        mul_b = mag_b;
        if (mul_done) begin
          state_next = FIX;
        end else if (cnt_reg == TMAX) begin
          state_next = DONE;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        ext_done   = 1'b1;
        ext_err    = err_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath, request registers, counter and cache
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_reg        <= 32'd0;
      op_b_reg        <= 32'd0;
      op_f_reg        <= 3'd0;
      cnt_reg         <= '0;
      prod_reg        <= 64'd0;
      r_reg           <= 32'd0;
      err_reg         <= 1'b0;
      cache_valid_reg <= 1'b0;
      cache_a_reg     <= 32'd0;
      cache_b_reg     <= 32'd0;
      cache_mode_reg  <= 2'd0;
      cache_p_reg     <= 64'd0;
    end else begin
      // The counter only runs in WAIT so every op starts counting from 0
      if (state_reg != WAIT) begin
        cnt_reg <= '0;
      end
      case (state_reg)
        IDLE: begin
          if (ext_start) begin
            op_a_reg <= ext_a;
            op_b_reg <= ext_b;
            op_f_reg <= ext_func3;
            if (ext_func3[2]) begin
              err_reg <= 1'b1;
              r_reg   <= 32'd0;
            end else if (cache_hit) begin
              err_reg <= 1'b0;
              r_reg   <= pick(ext_func3, cache_p_reg);
            end
          end
        end
        WAIT: begin
          if (mul_done) begin
            // Capture now: a pulsed mul_done may drop mul_p before FIX
            prod_reg <= mul_p;
          end else if (cnt_reg == TMAX) begin
            err_reg         <= 1'b1;
            r_reg           <= 32'd0;
            cache_valid_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FIX: begin
          err_reg         <= 1'b0;
          r_reg           <= pick(op_f_reg, fix_p);
          cache_valid_reg <= 1'b1;
          cache_a_reg     <= op_a_reg;
          cache_b_reg     <= op_b_reg;
          cache_mode_reg  <= op_f_reg[1:0];
          cache_p_reg     <= fix_p;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl -- directed, table-driven bench for mul_ctrl. The bench plays
// the multiplier: after mul_start it answers with the plain unsigned product
// of the magnitudes the controller presented, after a per-vector delay.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ext_start = 1'b0;
  logic [2:0]  ext_func3 = 3'd0;
  logic [31:0] ext_a = 32'd0;
  logic [31:0] ext_b = 32'd0;
  logic [31:0] ext_r;
  logic        ext_done, ext_err, busy, mul_start;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p = 64'd0;
  logic        mul_done = 1'b0;

  int total = 0;
  int bad = 0;

  mul_ctrl #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .ext_start(ext_start), .ext_func3(ext_func3), .ext_a(ext_a), .ext_b(ext_b),
    .ext_r(ext_r), .ext_done(ext_done), .ext_err(ext_err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;    // cycles from mul_start to mul_done, 0 = never
    bit          level;  // hold mul_done high instead of pulsing it
    bit          miss;   // expect a multiplier launch
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] r;
    bit          err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one request and follow it to ext_done (bounded at 400 cycles).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit level, input int inject,
                        output logic [31:0] r, output logic err, output int done_cyc,
                        output int starts, output logic [31:0] ma, output logic [31:0] mb,
                        output bit after_ok);
    int cyc;
    int launch;
    @(negedge clk);
    ext_start = 1'b1; ext_func3 = f; ext_a = a; ext_b = b;
    @(posedge clk);
    cyc = 0; launch = 0; done_cyc = 0; starts = 0;
    r = 32'd0; err = 1'b0; ma = 32'd0; mb = 32'd0;
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) ext_start = 1'b0;
      if (inject != 0 && cyc == inject) begin
        ext_start = 1'b1; ext_func3 = 3'b100;
      end
      if (inject != 0 && cyc == inject + 1) ext_start = 1'b0;
      if (!level) mul_done = 1'b0;
      if (mul_start) begin
        starts++;
        if (launch == 0) begin
          launch = cyc; ma = mul_a; mb = mul_b;
        end
      end
      if (lat > 0 && launch != 0 && cyc == launch + lat) begin
        mul_p = 64'(ma) * 64'(mb);
        mul_done = 1'b1;
      end
      if (ext_done) begin
        done_cyc = cyc; r = ext_r; err = ext_err;
      end
    end
    @(negedge clk);
    // One cycle later: pulse gone, back in IDLE, result still held
    after_ok = !ext_done && !busy && (ext_r == r);
    mul_done = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input bit level, input int inject,
                       input logic [31:0] exp_r, input bit exp_err, input int exp_lat,
                       input int exp_starts, input bit chk_mag,
                       input logic [31:0] exp_ma, input logic [31:0] exp_mb);
    logic [31:0] r, ma, mb;
    logic err;
    int done_cyc, starts;
    bit after_ok;
    run_op(f, a, b, lat, level, inject, r, err, done_cyc, starts, ma, mb, after_ok);
    $display("op %s f=%b a=%h b=%h -> r=%h err=%0d done_cyc=%0d starts=%0d",
             name, f, a, b, r, err, done_cyc, starts);
    chk({name, " ext_r"}, 64'(r), 64'(exp_r));
    chk({name, " ext_err"}, 64'(err), 64'(exp_err));
    chk({name, " latency"}, 64'(done_cyc), 64'(exp_lat));
    chk({name, " mul_start count"}, 64'(starts), 64'(exp_starts));
    chk({name, " after done"}, 64'(after_ok), 64'd1);
    if (chk_mag) begin
      chk({name, " mul_a"}, 64'(ma), 64'(exp_ma));
      chk({name, " mul_b"}, 64'(mb), 64'(exp_mb));
    end
  endtask

  initial begin
    bit seen;
    // f, a, b, lat, level, miss, mul_a, mul_b, ext_r, err
    vecs[0]  = '{3'b000, 32'd7,        32'd6,        2, 1'b0, 1'b1, 32'd7,        32'd6,        32'h0000002A, 1'b0};
    vecs[1]  = '{3'b000, 32'd7,        32'd6,        2, 1'b0, 1'b0, 32'd0,        32'd0,        32'h0000002A, 1'b0};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'd2,        3, 1'b0, 1'b1, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, 1'b0, 32'd0,        32'd0,        32'h00000001, 1'b0};
    vecs[5]  = '{3'b010, 32'h80000000, 32'd2,        4, 1'b0, 1'b1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b001, 32'h80000000, 32'h80000000, 2, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[7]  = '{3'b010, 32'h80000000, 32'h80000000, 6, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0};
    vecs[8]  = '{3'b000, 32'h80000000, 32'h80000000, 1, 1'b0, 1'b0, 32'd0,        32'd0,        32'h00000000, 1'b0};
    vecs[9]  = '{3'b100, 32'd7,        32'd6,        1, 1'b0, 1'b0, 32'd0,        32'd0,        32'h00000000, 1'b1};
    vecs[10] = '{3'b111, 32'h12345678, 32'h10,       1, 1'b0, 1'b0, 32'd0,        32'd0,        32'h00000000, 1'b1};
    vecs[11] = '{3'b001, 32'd5,        32'hFFFFFFFD, 3, 1'b1, 1'b1, 32'd5,        32'd3,        32'hFFFFFFFF, 1'b0};
    vecs[12] = '{3'b011, 32'd5,        32'hFFFFFFFD, 2, 1'b0, 1'b1, 32'd5,        32'hFFFFFFFD, 32'h00000004, 1'b0};
    vecs[13] = '{3'b000, 32'h12345678, 32'h10,       5, 1'b0, 1'b1, 32'h12345678, 32'h10,       32'h23456780, 1'b0};
    vecs[14] = '{3'b011, 32'h12345678, 32'h10,       1, 1'b0, 1'b1, 32'h12345678, 32'h10,       32'h00000001, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ext_done", 64'(ext_done), 64'd0);
    chk("reset ext_err", 64'(ext_err), 64'd0);
    chk("reset ext_r", 64'(ext_r), 64'd0);
    chk("reset mul_start", 64'(mul_start), 64'd0);
    chk("reset mul_a", 64'(mul_a), 64'd0);
    chk("reset mul_b", 64'(mul_b), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      do_op($sformatf("v%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].lat,
            vecs[i].level, 0, vecs[i].r, vecs[i].err,
            vecs[i].miss ? vecs[i].lat + 3 : 1, vecs[i].miss ? 1 : 0,
            vecs[i].miss, vecs[i].ma, vecs[i].mb);
    end

    // Timeout: 256 WAIT cycles (count 0..255), abort clears the cache
    do_op("to_prime", 3'b011, 32'h80000000, 32'd4, 2, 1'b0, 0, 32'd2, 1'b0, 5, 1, 1'b1, 32'h80000000, 32'd4);
    do_op("to_abort", 3'b000, 32'd9, 32'd9, 0, 1'b0, 0, 32'd0, 1'b1, 258, 1, 1'b1, 32'd9, 32'd9);
    do_op("to_after", 3'b011, 32'h80000000, 32'd4, 2, 1'b0, 0, 32'd2, 1'b0, 5, 1, 1'b0, 32'd0, 32'd0);
    do_op("to_retry", 3'b000, 32'd9, 32'd9, 3, 1'b0, 0, 32'd81, 1'b0, 6, 1, 1'b0, 32'd0, 32'd0);

    // ext_start during WAIT is ignored
    do_op("inject", 3'b000, 32'd11, 32'd13, 5, 1'b0, 3, 32'd143, 1'b0, 8, 1, 1'b0, 32'd0, 32'd0);

    // ext_start held high through DONE restarts on the next IDLE cycle
    @(negedge clk);
    ext_start = 1'b1; ext_func3 = 3'b100; ext_a = 32'd1; ext_b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    chk("held c1 ext_done", 64'(ext_done), 64'd1);
    @(negedge clk);
    chk("held c2 ext_done", 64'(ext_done), 64'd0);
    chk("held c2 busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("held c3 ext_done", 64'(ext_done), 64'd1);
    chk("held c3 ext_err", 64'(ext_err), 64'd1);
    ext_start = 1'b0;
    @(negedge clk);
    $display("op held_start restart checked");

    // Reset in the middle of WAIT, then a late mul_done while idle
    ext_start = 1'b1; ext_func3 = 3'b011; ext_a = 32'd21; ext_b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    ext_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midwait busy before reset", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midwait busy in reset", 64'(busy), 64'd0);
    chk("midwait mul_a in reset", 64'(mul_a), 64'd0);
    chk("midwait ext_r in reset", 64'(ext_r), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mul_p = 64'd42; mul_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ext_done || busy) seen = 1'b1;
    end
    chk("midwait no done after reset", 64'(seen), 64'd0);
    $display("op reset_mid_wait seen_activity=%0d", seen);
    // Reset also dropped the cached entry, so this must miss
    do_op("post_reset", 3'b000, 32'd7, 32'd6, 2, 1'b0, 0, 32'h2A, 1'b0, 5, 1, 1'b1, 32'd7, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
